// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: RV32I instruction-fetch front end.
// Holds the fetch PC and uses the external PC+4 adder for sequential flow.
// Keeps at most one instruction-memory request in flight and buffers
// returned words with their PCs in a 2-entry FIFO toward decode.
// Redirects from execute flush the FIFO. A response that belongs to
// pre-redirect flow is discarded through the DROP state.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] pc_o,
    input  logic [31:0] pc_plus4_i,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_pc_i,
    output logic        misalign_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        misalign_q, misalign_d;

    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_pc_q    [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;

    logic        imem_req_s;
    logic        instr_valid_s;
    logic        push_s;
    logic        pop_s;
    logic        flush_s;

    // A request is offered only from REQ and only when the FIFO has a free slot;
    // it is held low while reset is asserted so no grant is taken during reset.
    assign imem_req_s    = (state_q == ST_REQ) && (count_q < 2'd2) && !rst_i;
    assign instr_valid_s = (count_q != 2'd0);
    // A redirect flushes the FIFO, so a pop in the same cycle is meaningless.
    assign pop_s         = instr_valid_s && instr_ready_i && !redirect_en_i;

    assign pc_o          = pc_q;
    assign imem_addr_o   = pc_q;
    assign imem_req_o    = imem_req_s;
    assign misalign_o    = misalign_q;
    assign instr_valid_o = instr_valid_s;
    assign instr_o       = fifo_instr_q[rd_ptr_q];
    assign instr_pc_o    = fifo_pc_q[rd_ptr_q];

    // Next-state, next-PC, push and flush decisions; redirect has priority.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        misalign_d = 1'b0;
        push_s     = 1'b0;
        flush_s    = 1'b0;
        if (redirect_en_i) begin
            flush_s    = 1'b1;
            pc_d       = {redirect_pc_i[31:2], 2'b00};
            misalign_d = |redirect_pc_i[1:0];
            case (state_q)
                // A request granted this cycle is still in flight: drop its data.
                ST_REQ:  state_d = (imem_req_s && imem_gnt_i) ? ST_DROP : ST_REQ;
                ST_WAIT: state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
                ST_DROP: state_d = imem_rvalid_i ? ST_REQ : ST_DROP;
                default: state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem_req_s && imem_gnt_i) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_plus4_i;
                        state_d  = ST_WAIT;
                    end else begin
                        state_d  = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid_i) begin
                        push_s  = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DROP: begin
                    if (imem_rvalid_i) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Fetch control registers: state, PC, outstanding-request PC, misalign pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Two-entry instruction FIFO with pointer wrap; flush clears occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_instr_q[0] <= 32'h0000_0000;
            fifo_instr_q[1] <= 32'h0000_0000;
            fifo_pc_q[0]    <= 32'h0000_0000;
            fifo_pc_q[1]    <= 32'h0000_0000;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else if (flush_s) begin
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
                fifo_pc_q[wr_ptr_q]    <= req_pc_q;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed, table-driven testbench for pc_fetch_unit.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        misalign;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int n_checks;
    int n_pass;

    // External PC+4 adder model.
    assign pc_plus4 = pc + 32'd4;

    pc_fetch_unit #(.RESET_PC(32'h0000_1000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_o          (pc),
        .pc_plus4_i    (pc_plus4),
        .redirect_en_i (redirect_en),
        .redirect_pc_i (redirect_pc),
        .misalign_o    (misalign),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        re;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_mis;
    } vec_t;

    vec_t tbl [30];

    // Memory data pattern: tag plus low half of the address.
    function automatic logic [31:0] dw(input logic [31:0] a);
        return 32'hC0DE_0000 | (a & 32'h0000_FFFF);
    endfunction

    function automatic vec_t mk(input logic rdy, input logic gnt, input logic rv,
                                input logic [31:0] rdata, input logic re,
                                input logic [31:0] rpc, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_ipc,
                                input logic e_mis);
        vec_t v;
        v.rdy = rdy; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.re = re; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and check the outputs.
    task automatic apply_row(input vec_t v, input string tag);
        @(negedge clk);
        instr_ready = v.rdy;
        imem_gnt    = v.gnt;
        imem_rvalid = v.rv;
        imem_rdata  = v.rdata;
        redirect_en = v.re;
        redirect_pc = v.rpc;
        #1;
        check({tag, " req"},      {31'd0, imem_req},    {31'd0, v.e_req});
        check({tag, " addr"},     imem_addr,            v.e_addr);
        check({tag, " pc"},       pc,                   v.e_addr);
        check({tag, " valid"},    {31'd0, instr_valid}, {31'd0, v.e_valid});
        check({tag, " misalign"}, {31'd0, misalign},    {31'd0, v.e_mis});
        if (v.e_valid) begin
            check({tag, " instr"},    instr,    v.e_instr);
            check({tag, " instr_pc"}, instr_pc, v.e_ipc);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        instr_ready = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;

        // Zero-wait fetch stream from RESET_PC.
        tbl[0]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h1000,1'b0,32'h0,32'h0,1'b0);
        tbl[1]  = mk(1'b1,1'b0,1'b1,dw(32'h1000),1'b0,32'h0, 1'b0,32'h1004,1'b0,32'h0,32'h0,1'b0);
        tbl[2]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h1004,1'b1,dw(32'h1000),32'h1000,1'b0);
        tbl[3]  = mk(1'b1,1'b0,1'b1,dw(32'h1004),1'b0,32'h0, 1'b0,32'h1008,1'b0,32'h0,32'h0,1'b0);
        tbl[4]  = mk(1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h1008,1'b1,dw(32'h1004),32'h1004,1'b0);
        tbl[5]  = mk(1'b1,1'b0,1'b1,dw(32'h1008),1'b0,32'h0, 1'b0,32'h100C,1'b0,32'h0,32'h0,1'b0);
        // Decode stalls for 10 cycles: FIFO fills to 2 and requests stop.
        tbl[6]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h100C,1'b1,dw(32'h1008),32'h1008,1'b0);
        tbl[7]  = mk(1'b0,1'b0,1'b1,dw(32'h100C),1'b0,32'h0, 1'b0,32'h1010,1'b1,dw(32'h1008),32'h1008,1'b0);
        for (int i = 8; i < 16; i++) begin
            tbl[i] = mk(1'b0,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h1010,1'b1,dw(32'h1008),32'h1008,1'b0);
        end
        // One pop, then the request reappears with the next PC.
        tbl[16] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h1010,1'b1,dw(32'h1008),32'h1008,1'b0);
        tbl[17] = mk(1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h1010,1'b1,dw(32'h100C),32'h100C,1'b0);
        tbl[18] = mk(1'b1,1'b0,1'b1,dw(32'h1010),1'b0,32'h0, 1'b0,32'h1014,1'b0,32'h0,32'h0,1'b0);
        tbl[19] = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h1014,1'b1,dw(32'h1010),32'h1010,1'b0);
        // Redirect to 0x2000 while 0x1014 is outstanding: response dropped.
        tbl[20] = mk(1'b0,1'b0,1'b0,32'h0,1'b1,32'h2000, 1'b0,32'h1018,1'b1,dw(32'h1010),32'h1010,1'b0);
        tbl[21] = mk(1'b1,1'b0,1'b1,dw(32'h1014),1'b0,32'h0, 1'b0,32'h2000,1'b0,32'h0,32'h0,1'b0);
        // Redirect to 0x3000 together with GNT; RVALID three cycles later.
        tbl[22] = mk(1'b1,1'b1,1'b0,32'h0,1'b1,32'h3000, 1'b1,32'h2000,1'b0,32'h0,32'h0,1'b0);
        tbl[23] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h3000,1'b0,32'h0,32'h0,1'b0);
        tbl[24] = mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b0,32'h3000,1'b0,32'h0,32'h0,1'b0);
        tbl[25] = mk(1'b1,1'b0,1'b1,dw(32'h2000),1'b0,32'h0, 1'b0,32'h3000,1'b0,32'h0,32'h0,1'b0);
        // Misaligned redirect to 0x102.
        tbl[26] = mk(1'b1,1'b0,1'b0,32'h0,1'b1,32'h0102, 1'b1,32'h3000,1'b0,32'h0,32'h0,1'b0);
        tbl[27] = mk(1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h0100,1'b0,32'h0,32'h0,1'b1);
        tbl[28] = mk(1'b1,1'b0,1'b1,dw(32'h0100),1'b0,32'h0, 1'b0,32'h0104,1'b0,32'h0,32'h0,1'b0);
        tbl[29] = mk(1'b0,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h0104,1'b1,dw(32'h0100),32'h0100,1'b0);

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("reset req",      {31'd0, imem_req},    32'd0);
        check("reset valid",    {31'd0, instr_valid}, 32'd0);
        check("reset instr",    instr,                32'd0);
        check("reset instr_pc", instr_pc,             32'd0);
        check("reset misalign", {31'd0, misalign},    32'd0);
        check("reset pc",       pc,                   32'h1000);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            apply_row(tbl[i], $sformatf("row%0d", i));
        end

        // Reset taken mid-WAIT with one entry buffered; late response follows.
        @(negedge clk);
        rst         = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        #1;
        check("rst_mid req during reset", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = dw(32'h0104);
        #1;
        check("rst_mid valid", {31'd0, instr_valid}, 32'd0);
        check("rst_mid pc",    pc,                   32'h1000);
        check("rst_mid req",   {31'd0, imem_req},    32'd1);
        apply_row(mk(1'b0,1'b0,1'b0,32'h0,1'b1,32'hFFFF_FFFC, 1'b1,32'h1000,1'b0,32'h0,32'h0,1'b0), "late_drop");

        // PC wrap from 0xFFFF_FFFC to 0.
        apply_row(mk(1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'hFFFF_FFFC,1'b0,32'h0,32'h0,1'b0), "wrap0");
        apply_row(mk(1'b1,1'b0,1'b1,dw(32'hFFFC),1'b0,32'h0, 1'b0,32'h0000_0000,1'b0,32'h0,32'h0,1'b0), "wrap1");
        apply_row(mk(1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h0000_0000,1'b1,dw(32'hFFFC),32'hFFFF_FFFC,1'b0), "wrap2");
        // Redirect in WAIT coinciding with RVALID: response discarded, request next cycle.
        apply_row(mk(1'b1,1'b0,1'b1,32'h0BAD_0BAD,1'b1,32'h4000, 1'b0,32'h0000_0004,1'b0,32'h0,32'h0,1'b0), "wrv0");
        apply_row(mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h4000,1'b0,32'h0,32'h0,1'b0), "wrv1");
        apply_row(mk(1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 1'b1,32'h4000,1'b0,32'h0,32'h0,1'b0), "wrv2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
